// File: rtl/mem_pkg.sv
// mem_pkg: shared MemOp codes, FSM states and counter sizing for the memory stage.
package mem_pkg;
  localparam logic [2:0] MEMOP_W  = 3'd0;
  localparam logic [2:0] MEMOP_H  = 3'd1;
  localparam logic [2:0] MEMOP_HU = 3'd2;
  localparam logic [2:0] MEMOP_B  = 3'd3;
  localparam logic [2:0] MEMOP_BU = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication/byte enables, load lane extraction and alignment check.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic        store,
  input  logic [31:0] wd,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        bad
);
  logic is_b, is_h;
  logic [31:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_b = op == MEMOP_B || op == MEMOP_BU;
    is_h = op == MEMOP_H || op == MEMOP_HU;
    bad = op > MEMOP_BU || (op == MEMOP_W && off != 2'b00) || (is_h && off[0]);
    be = (!store || op == MEMOP_W) ? 4'hf : is_h ? (off[1] ? 4'hc : 4'h3) : 4'b0001 << off;
    wdata = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
    sh = rdata >> {ld_off, 3'b000};
    b = sh[7:0];
    h = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ldata = ld_op == MEMOP_B  ? {{24{b[7]}}, b} :
            ld_op == MEMOP_BU ? {24'b0, b} :
            ld_op == MEMOP_H  ? {{16{h[15]}}, h} :
            ld_op == MEMOP_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage req/ack controller with pipeline stall, lane steering and load extension.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [2:0]  MemOp_M,
  input  logic [31:0] result_M,
  input  logic [31:0] wd_M,
  output logic [31:0] dout,
  output logic        stall_M,
  output logic        addr_err_M,
  output logic        bus_err_M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int CW = cnt_width(TIMEOUT);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [1:0] off_q;
  logic [3:0] be;
  logic [31:0] wdata, ldata;
  logic bad, access, timeout;
  mem_lane_align u_align (
    .op(MemOp_M), .off(result_M[1:0]), .store(MemWrite_M), .wd(wd_M),
    .ld_op(op_q), .ld_off(off_q), .rdata(mem_rdata),
    .be(be), .wdata(wdata), .ldata(ldata), .bad(bad)
  );
  always_comb begin
    addr_err_M = (MemRead_M && MemWrite_M) || ((MemRead_M || MemWrite_M) && bad);
    access = (MemRead_M || MemWrite_M) && !addr_err_M;
    // cnt counts completed ack-less WAIT cycles, so this fires on the TIMEOUT-th one
    timeout = state == ST_WAIT && !mem_ack && cnt == CW'(TIMEOUT - 1);
    stall_M = (state == ST_IDLE && access) || state == ST_WAIT;
    nxt = state == ST_IDLE ? (access ? ST_WAIT : ST_IDLE) :
          state == ST_WAIT ? ((mem_ack || timeout) ? ST_DONE : ST_WAIT) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      op_q <= '0;
      off_q <= '0;
      dout <= '0;
      bus_err_M <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= nxt;
      bus_err_M <= timeout;
      if (state == ST_IDLE && access) begin
        mem_req <= 1'b1;
        mem_we <= MemWrite_M;
        mem_be <= be;
        mem_addr <= {result_M[31:2], 2'b00};
        mem_wdata <= wdata;
        op_q <= MemOp_M;
        off_q <= result_M[1:0];
        cnt <= '0;
      end
      if (state == ST_WAIT) begin
        if (mem_ack || timeout) begin
          mem_req <= 1'b0;
          if (!mem_we) dout <= mem_ack ? ldata : 32'd0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the memory-stage access controller (TIMEOUT = 4).
module tb_mem_access_unit;
  logic clk = 0, rst = 1;
  logic MemRead_M = 0, MemWrite_M = 0, mem_ack = 0;
  logic [2:0] MemOp_M = 0;
  logic [31:0] result_M = 0, wd_M = 0, mem_rdata = 0;
  logic [31:0] dout, mem_addr, mem_wdata;
  logic stall_M, addr_err_M, bus_err_M, mem_req, mem_we;
  logic [3:0] mem_be;
  int checks = 0, failures = 0;
  int stalls;
  logic [31:0] q_addr, q_wdata;
  logic [3:0] q_be;
  logic q_we;
  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .MemOp_M(MemOp_M), .result_M(result_M), .wd_M(wd_M), .dout(dout),
    .stall_M(stall_M), .addr_err_M(addr_err_M), .bus_err_M(bus_err_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    MemRead_M = 0; MemWrite_M = 0; MemOp_M = 0; result_M = 0; wd_M = 0;
    tick();
  endtask
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int ack_at,
                           output int n, output logic [31:0] qa, output logic [3:0] qb,
                           output logic [31:0] qw, output logic qwe);
    MemRead_M = rd; MemWrite_M = wr; MemOp_M = op; result_M = a; wd_M = wd;
    n = 0; qa = 'x; qb = 'x; qw = 'x; qwe = 'x;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall_M) break;
      n++;
      if (c >= 1) chk("req_held", mem_req, 1'b1);
      if (c == 1) begin
        qa = mem_addr; qb = mem_be; qw = mem_wdata; qwe = mem_we;
      end
      mem_ack = (c == ack_at);
      mem_rdata = rdat;
      @(posedge clk);
      #1;
      mem_ack = 0;
    end
  endtask
  initial begin
    tick(); tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_buserr", bus_err_M, 1'b0);
    chk("rst_stall", stall_M, 1'b0);
    rst = 0;
    tick();
    do_access(1, 0, 3'd3, 32'h1003, 0, 32'h80112233, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("lb_stalls", stalls, 2);
    chk("lb_addr", q_addr, 32'h1000);
    chk("lb_be", q_be, 4'hf);
    chk("lb_we", q_we, 1'b0);
    chk("lb_dout", dout, 32'hFFFFFF80);
    chk("lb_done_req", mem_req, 1'b0);
    idle();
    do_access(1, 0, 3'd2, 32'h2002, 0, 32'hBEEF1234, 3, stalls, q_addr, q_be, q_wdata, q_we);
    chk("lhu_stalls", stalls, 4);
    chk("lhu_addr", q_addr, 32'h2000);
    chk("lhu_dout", dout, 32'h0000BEEF);
    idle();
    do_access(0, 1, 3'd1, 32'h10, 32'h0000ABCD, 32'hFFFFFFFF, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("sh_stalls", stalls, 2);
    chk("sh_we", q_we, 1'b1);
    chk("sh_be", q_be, 4'h3);
    chk("sh_wdata", q_wdata, 32'hABCDABCD);
    chk("sh_dout", dout, 32'h0000BEEF);
    idle();
    do_access(0, 1, 3'd3, 32'h13, 32'h1234565A, 0, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("sb_be", q_be, 4'h8);
    chk("sb_wdata", q_wdata, 32'h5A5A5A5A);
    chk("sb_addr", q_addr, 32'h10);
    idle();
    do_access(0, 1, 3'd1, 32'h22, 32'h00001357, 0, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("sh_hi_be", q_be, 4'hc);
    idle();
    do_access(0, 1, 3'd0, 32'h20, 32'hDEADBEEF, 0, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("sw_be", q_be, 4'hf);
    chk("sw_wdata", q_wdata, 32'hDEADBEEF);
    idle();
    do_access(1, 0, 3'd4, 32'h1001, 0, 32'h0000F000, 2, stalls, q_addr, q_be, q_wdata, q_we);
    chk("lbu_stalls", stalls, 3);
    chk("lbu_dout", dout, 32'h000000F0);
    idle();
    do_access(1, 0, 3'd1, 32'h1002, 0, 32'h9ABC0000, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("lh_dout", dout, 32'hFFFF9ABC);
    idle();
    MemRead_M = 1; MemOp_M = 3'd0; result_M = 32'h6; #1;
    chk("lw_mis_err", addr_err_M, 1'b1);
    chk("lw_mis_stall", stall_M, 1'b0);
    tick();
    chk("lw_mis_req", mem_req, 1'b0);
    MemRead_M = 0; MemWrite_M = 1; MemOp_M = 3'd1; result_M = 32'h5; #1;
    chk("sh_mis_err", addr_err_M, 1'b1);
    chk("sh_mis_stall", stall_M, 1'b0);
    tick();
    chk("sh_mis_req", mem_req, 1'b0);
    MemWrite_M = 0; MemRead_M = 1; MemOp_M = 3'd6; result_M = 32'h0; #1;
    chk("rsv_err", addr_err_M, 1'b1);
    chk("rsv_stall", stall_M, 1'b0);
    tick();
    chk("rsv_req", mem_req, 1'b0);
    MemWrite_M = 1; MemOp_M = 3'd0; #1;
    chk("rdwr_err", addr_err_M, 1'b1);
    chk("rdwr_stall", stall_M, 1'b0);
    MemRead_M = 0; MemWrite_M = 0; MemOp_M = 3'd6; result_M = 32'h7; #1;
    chk("noacc_err", addr_err_M, 1'b0);
    tick();
    chk("err_dout", dout, 32'hFFFF9ABC);
    idle();
    do_access(1, 0, 3'd0, 32'h100, 0, 32'h11111111, -1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("to_stalls", stalls, 5);
    chk("to_buserr", bus_err_M, 1'b1);
    chk("to_dout", dout, 32'h0);
    chk("to_req", mem_req, 1'b0);
    idle();
    chk("to_buserr_pulse", bus_err_M, 1'b0);
    do_access(1, 0, 3'd0, 32'h30, 0, 32'h12345678, 1, stalls, q_addr, q_be, q_wdata, q_we);
    chk("lw_dout", dout, 32'h12345678);
    idle();
    MemRead_M = 1; MemOp_M = 3'd0; result_M = 32'h40;
    tick();
    chk("rw_req", mem_req, 1'b1);
    rst = 1; MemRead_M = 0;
    tick();
    chk("rw_req_cleared", mem_req, 1'b0);
    chk("rw_dout", dout, 32'h0);
    chk("rw_stall", stall_M, 1'b0);
    rst = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 0;
    chk("rw_ack_ignored_dout", dout, 32'h0);
    chk("rw_ack_ignored_req", mem_req, 1'b0);
    tick();
    chk("rw_no_req", mem_req, 1'b0);
    chk("rw_no_stall", stall_M, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
